// File: rtl/tocador_notas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tocador_notas : note sequencer feeding the buzzer seletor/tom/toca inputs. |
// | Optional TOCADOR_PARAR_EN adds a 'parar' flush input.  Revision: 1.0       |
// +----------------------------------------------------------------------------+
module tocador_notas #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int TOM        = 4,
    parameter int DEPTH      = 4,
    parameter int UNIT_MS    = 10,
    parameter int GAP_UNITS  = 2,
    localparam int TW        = (TOM > 1) ? $clog2(TOM) : 1
) (
    input  logic          clock,
    input  logic          reset,
`ifdef TOCADOR_PARAR_EN
    input  logic          parar,
`endif
    input  logic          note_valid,
    output logic          note_ready,
    input  logic [3:0]    note_seletor,
    input  logic [TW-1:0] note_tom,
    input  logic [5:0]    note_dur,
    output logic [3:0]    seletor,
    output logic [TW-1:0] tom,
    output logic          toca,
    output logic          tocando,
    output logic          fim_nota
);

    localparam int UNIT_CYCLES = CLOCK_FREQ / 1000 * UNIT_MS;
    localparam int CW          = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int AW          = $clog2(DEPTH);
    localparam int EW          = 4 + TW + 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    state_t        state_q;
    logic [CW-1:0] cyc_q;
    logic [5:0]    unit_q;
    logic [3:0]    sel_q;
    logic [TW-1:0] tom_q;
    logic          toca_q;
    logic          fim_q;

    logic          flush;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic [3:0]    head_sel;
    logic [TW-1:0] head_tom;
    logic [5:0]    head_dur;
    logic          unit_end;

`ifdef TOCADOR_PARAR_EN
    assign flush = parar;
`else
    assign flush = 1'b0;
`endif

    assign note_ready = (count_q != (AW+1)'(DEPTH));
    assign push       = note_valid && note_ready && !flush;
    assign pop        = (state_q == S_LOAD) && !flush;

    assign head     = mem_q[rd_ptr_q];
    assign head_dur = head[5:0];
    assign head_tom = head[6 +: TW];
    assign head_sel = head[EW-1 -: 4];
    assign unit_end = (cyc_q == CW'(UNIT_CYCLES - 1));

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {note_seletor, note_tom, note_dur};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            sel_q   <= '0;
            tom_q   <= '0;
            toca_q  <= 1'b0;
            fim_q   <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            toca_q  <= 1'b0;
            fim_q   <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sel_q  <= head_sel;
                    tom_q  <= head_tom;
                    cyc_q  <= '0;
                    unit_q <= head_dur;
                    // A zero-length entry is dropped without a note cycle.
                    if (head_dur == 6'd0) begin
                        state_q <= (count_q > (AW+1)'(1)) ? S_LOAD : S_IDLE;
                    end else begin
                        state_q <= S_PLAY;
                        toca_q  <= (head_sel < 4'd12);
                    end
                end
                S_PLAY: begin
                    if (unit_end) begin
                        cyc_q <= '0;
                        if (unit_q == 6'd1) begin
                            state_q <= S_GAP;
                            toca_q  <= 1'b0;
                            fim_q   <= 1'b1;
                            unit_q  <= 6'(GAP_UNITS);
                        end else begin
                            unit_q <= unit_q - 6'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (unit_end) begin
                        cyc_q <= '0;
                        if (unit_q == 6'd1) begin
                            state_q <= (count_q != '0) ? S_LOAD : S_IDLE;
                        end else begin
                            unit_q <= unit_q - 6'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign seletor  = sel_q;
    assign tom      = tom_q;
    assign toca     = toca_q;
    assign fim_nota = fim_q;
    assign tocando  = (state_q != S_IDLE);

endmodule
`default_nettype wire
